byte_serializer: RTL and testbench

- Downstream consumer of the splitter in the cpu_v1 datapath.
- Takes one split 16-bit word as a low/high byte pair and emits it as two sequential bytes on an 8-bit valid/ready stream.
- Drives the processor's 8-bit external/memory byte bus.
- Sustains one byte per cycle: the next word is accepted in the same cycle the last byte of the current word is consumed.

---
 rtl/byte_serializer_if.sv | 30 +++
 rtl/byte_serializer.sv | 114 +++++++++++
 tb/tb_byte_serializer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_serializer_if.sv
// ---------------------------------------------------------------------------
// byte_serializer_if : word-in / byte-out valid-ready stream bundle
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface byte_serializer_if;
  logic       in_valid;
  logic [7:0] in_low;
  logic [7:0] in_high;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  // Word producer and byte sink side (the environment around the serializer)
  modport master (
    output in_valid, in_low, in_high, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Serializer side
  modport slave (
    input  in_valid, in_low, in_high, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

`default_nettype wire

// File: rtl/byte_serializer.sv
// ---------------------------------------------------------------------------
// byte_serializer : emits a 16-bit low/high byte pair as two stream bytes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module byte_serializer #(
  parameter int HIGH_FIRST = 0,
  parameter int CNT_W      = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  byte_serializer_if.slave      bus,
  output logic [CNT_W-1:0]      word_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_t;

  localparam bit HF = (HIGH_FIRST != 0);

  state_t           state_q, state_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [7:0]       second_q, second_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             in_ready;
  logic             capture;
  logic [7:0]       first_in;
  logic [7:0]       second_in;

  // Accepting in SEND1 relies on the last byte leaving in the same cycle,
  // which keeps the stream gap-free.
  assign in_ready  = (state_q == IDLE) | ((state_q == SEND1) & bus.out_ready);
  assign capture   = bus.in_valid & in_ready;
  assign first_in  = HF ? bus.in_high : bus.in_low;
  assign second_in = HF ? bus.in_low  : bus.in_high;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    second_d    = second_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    count_d     = count_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = SEND0;
        end
      end
      SEND0: begin
        if (bus.out_ready) begin
          state_d    = SEND1;
          out_data_d = second_q;
          out_last_d = 1'b1;
        end
      end
      SEND1: begin
        if (bus.out_ready) begin
          count_d     = count_q + CNT_W'(1);
          state_d     = bus.in_valid ? SEND0 : IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    if (capture) begin
      out_data_d  = first_in;
      second_d    = second_in;
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_data_q  <= 8'h00;
      second_q    <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      second_q    <= second_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign word_count    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_byte_serializer.sv
// ---------------------------------------------------------------------------
// tb_byte_serializer : directed bench with a queue-based byte-order model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_byte_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_word;
  logic        out_ready;
  logic [15:0] wc_a;
  logic [1:0]  wc_b;

  int vectors;
  int miscompares;

  // Model: bytes still owed to the sink; bit 16 marks the second byte of a word
  logic [16:0] mq[$];
  int unsigned mcnt;
  bit          minit;
  bit          macc;

  logic [15:0] words [4] = '{16'h00FF, 16'h8001, 16'hAA00, 16'h55AA};
  logic [7:0]  eb    [8] = '{8'hFF, 8'h00, 8'h01, 8'h80, 8'h00, 8'hAA, 8'hAA, 8'h55};
  logic [1:0]  wseq  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  byte_serializer_if ifa ();
  byte_serializer_if ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_low    = in_word[7:0];
  assign ifa.in_high   = in_word[15:8];
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_low    = in_word[7:0];
  assign ifb.in_high   = in_word[15:8];
  assign ifb.out_ready = out_ready;

  byte_serializer #(.HIGH_FIRST(0), .CNT_W(16)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifa.slave),
    .word_count (wc_a)
  );

  byte_serializer #(.HIGH_FIRST(1), .CNT_W(2)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifb.slave),
    .word_count (wc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [16:0] e, input bit hf);
    return (e[16] ^ hf) ? e[15:8] : e[7:0];
  endfunction

  // One clock: compare against the model mid-cycle, then advance the model
  // on the rising edge using the same inputs the DUTs sample.
  task automatic cycle();
    logic [16:0] head;
    bit          exp_rdy;
    @(negedge clk);
    exp_rdy = (mq.size() == 0) || (mq.size() == 1 && out_ready);
    if (minit) begin
      chk("in_ready_a", ifa.in_ready, exp_rdy);
      chk("in_ready_b", ifb.in_ready, exp_rdy);
      chk("out_valid_a", ifa.out_valid, mq.size() > 0);
      chk("out_valid_b", ifb.out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("out_data_a", ifa.out_data, exp_byte(mq[0], 1'b0));
        chk("out_data_b", ifb.out_data, exp_byte(mq[0], 1'b1));
        chk("out_last_a", ifa.out_last, mq[0][16]);
        chk("out_last_b", ifb.out_last, mq[0][16]);
      end
      chk("word_count_a", wc_a, mcnt[15:0]);
      chk("word_count_b", wc_b, mcnt[1:0]);
    end
    @(posedge clk);
    exp_rdy = (mq.size() == 0) || (mq.size() == 1 && out_ready);
    if (rst) begin
      mq.delete();
      mcnt  = 0;
      minit = 1'b1;
      macc  = 1'b0;
    end else begin
      macc = in_valid && exp_rdy;
      if (mq.size() > 0 && out_ready) begin
        head = mq.pop_front();
        if (head[16]) mcnt++;
      end
      if (macc) begin
        mq.push_back({1'b0, in_word});
        mq.push_back({1'b1, in_word});
      end
    end
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && ifa.out_valid; i++) cycle();
    chk("drain_timeout", ifa.out_valid, 1'b0);
  endtask

  initial begin
    int idx;
    int n;
    vectors     = 0;
    miscompares = 0;
    minit       = 1'b0;
    mcnt        = 0;
    macc        = 1'b0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_word     = 16'h0000;
    out_ready   = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_valid", ifa.out_valid, 1'b0);
    chk("rst_last", ifa.out_last, 1'b0);
    chk("rst_data", ifa.out_data, 8'h00);
    chk("rst_count", wc_a, 16'd0);

    // Single word 16'hFF00
    in_valid = 1'b1; in_word = 16'hFF00; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("t1_b0", ifa.out_data, 8'h00);
    chk("t1_l0", ifa.out_last, 1'b0);
    chk("t1_b0_hf", ifb.out_data, 8'hFF);
    cycle();
    chk("t1_b1", ifa.out_data, 8'hFF);
    chk("t1_l1", ifa.out_last, 1'b1);
    cycle();
    chk("t1_idle", ifa.out_valid, 1'b0);
    chk("t1_count", wc_a, 16'd1);

    // Back-to-back stream, no bubbles
    idx = 0; n = 0; out_ready = 1'b1;
    for (int c = 0; c < 20 && n < 8; c++) begin
      in_valid = (idx < 4);
      in_word  = words[(idx < 4) ? idx : 3];
      cycle();
      if (macc) idx++;
      if (ifa.out_valid) begin
        if (n < 8) chk("b2b_byte", ifa.out_data, eb[n]);
        n++;
      end
    end
    chk("b2b_nbytes", n, 8);
    drain();
    chk("b2b_count", wc_a, 16'd5);

    // Backpressure in both byte phases; later input must be ignored
    in_valid = 1'b1; in_word = 16'h8001; out_ready = 1'b0;
    cycle();
    in_word = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_s0_data", ifa.out_data, 8'h01);
      chk("bp_s0_rdy", ifa.in_ready, 1'b0);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("bp_s1_data", ifa.out_data, 8'h80);
      chk("bp_s1_last", ifa.out_last, 1'b1);
      chk("bp_s1_rdy", ifa.in_ready, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("bp_idle", ifa.out_valid, 1'b0);
    chk("bp_count", wc_a, 16'd6);

    // Byte order for both settings on 16'h55AA
    in_valid = 1'b1; in_word = 16'h55AA; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("hf_a0", ifa.out_data, 8'hAA);
    chk("hf_b0", ifb.out_data, 8'h55);
    chk("hf_b0_last", ifb.out_last, 1'b0);
    cycle();
    chk("hf_a1", ifa.out_data, 8'h55);
    chk("hf_b1", ifb.out_data, 8'hAA);
    chk("hf_b1_last", ifb.out_last, 1'b1);
    cycle();
    chk("hf_count_a", wc_a, 16'd7);
    chk("hf_count_b", wc_b, 2'd3);

    // Reset in SEND1 with a pending word
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    in_valid = 1'b1; in_word = 16'h1234; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("rs_in_send1", ifa.out_last, 1'b1);
    rst = 1'b1; in_valid = 1'b1; in_word = 16'h4321;
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    chk("rs_valid", ifa.out_valid, 1'b0);
    chk("rs_count", wc_a, 16'd0);
    cycle();
    chk("rs_no_capture", ifa.out_valid, 1'b0);

    // Narrow counter wrap
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_word = 16'h0101 * (i + 1); out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();
      cycle();
      chk("wrap_count_b", wc_b, wseq[i]);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

endmodule

`default_nettype wire
